// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - handshake, status and PS/2 line bundle for ps2_host_tx
// Signals:
//   tx_valid/tx_data/tx_ready : byte request handshake (master -> slave)
//   tx_busy/tx_done/tx_err    : transfer status (slave -> master)
//   ps2_clk_in/ps2_data_in    : raw PS/2 line levels seen at the pads
//   ps2_clk_oe/ps2_data_oe    : open-drain pull-down enables toward the pads
// Modports: master = requester and pad side, slave = ps2_host_tx.
interface ps2_host_tx_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_err;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;

   modport master (
      output tx_valid, tx_data, ps2_clk_in, ps2_data_in,
      input  tx_ready, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
   );

   modport slave (
      input  tx_valid, tx_data, ps2_clk_in, ps2_data_in,
      output tx_ready, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
   );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Purpose: sends one byte to a PS/2 device (inhibit, request-to-send, 11-bit
//   device-clocked frame, ack check) driving the lines open-drain via oe outputs.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : ps2_host_tx_if.slave (tx_valid/tx_data/tx_ready handshake,
//          tx_busy/tx_done/tx_err status, raw line inputs, line pull-down enables)
// Optional feature: define PS2_TX_RETRY_EN to retry up to 2 times on nack/timeout.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 12000,
   parameter int RTS_CYCLES     = 2000,
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int FILT_LEN       = 8
) (
   input  logic         clk,
   input  logic         rst,
   ps2_host_tx_if.slave bus
);
   localparam int          FW       = $clog2(FILT_LEN + 1);
   localparam logic [20:0] INH_LAST = 21'(INHIBIT_CYCLES - 1);
   localparam logic [20:0] RTS_LAST = 21'(RTS_CYCLES - 1);
   localparam logic [20:0] TO_LAST  = 21'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_IDLE
   } state_t;

   state_t        state_q, state_d;
   logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic          filt_q, filt_prev_q;
   logic [FW-1:0] filt_cnt_q;
   logic [20:0]   cyc_q;
   logic [3:0]    edge_q;
   logic [7:0]    shift_q;
   logic          parity_q, bit_q, nack_q, done_q, err_q;

   logic          clk_fall, accept, timeout, line_idle, finish, fail, can_retry, enter_inh;
   logic [7:0]    load_byte;

   assign clk_fall  = filt_prev_q & ~filt_q;
   assign accept    = bus.tx_valid && (state_q == S_IDLE);
   assign timeout   = (state_q inside {S_SEND, S_ACK, S_WAIT_IDLE}) && (cyc_q >= TO_LAST);
   assign line_idle = clk_s2_q & dat_s2_q;
   assign finish    = timeout || ((state_q == S_WAIT_IDLE) && line_idle);
   assign fail      = timeout || nack_q;
   assign enter_inh = (state_d == S_INHIBIT) && (state_q != S_INHIBIT);

`ifdef PS2_TX_RETRY_EN
   logic [7:0] byte_q;
   logic [1:0] retry_q;

   assign can_retry = (retry_q != 2'd2);
   // Retries reload the shift register from the byte captured at accept.
   assign load_byte = accept ? bus.tx_data : byte_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_q  <= '0;
         retry_q <= '0;
      end else if (accept) begin
         byte_q  <= bus.tx_data;
         retry_q <= '0;
      end else if (finish && fail && can_retry) begin
         retry_q <= retry_q + 2'd1;
      end
   end
`else
   assign can_retry = 1'b0;
   assign load_byte = bus.tx_data;
`endif

   // Line synchronizers and clock-line glitch filter; lines idle high.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1_q    <= 1'b1;
         clk_s2_q    <= 1'b1;
         dat_s1_q    <= 1'b1;
         dat_s2_q    <= 1'b1;
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
         filt_cnt_q  <= '0;
      end else begin
         clk_s1_q    <= bus.ps2_clk_in;
         clk_s2_q    <= clk_s1_q;
         dat_s1_q    <= bus.ps2_data_in;
         dat_s2_q    <= dat_s1_q;
         filt_prev_q <= filt_q;
         // Accept a new level only after FILT_LEN consecutive differing samples.
         if (clk_s2_q == filt_q) begin
            filt_cnt_q <= '0;
         end else if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
            filt_q     <= clk_s2_q;
            filt_cnt_q <= '0;
         end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (accept) state_d = S_INHIBIT;
         S_INHIBIT:   if (cyc_q == INH_LAST) state_d = S_RTS;
         S_RTS:       if (cyc_q == RTS_LAST) state_d = S_SEND;
         S_SEND:      if (clk_fall && (edge_q == 4'd9)) state_d = S_ACK;
         S_ACK:       if (clk_fall) state_d = S_WAIT_IDLE;
         S_WAIT_IDLE: if (line_idle) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
      if (timeout) state_d = S_IDLE;
      if (finish && fail && can_retry) state_d = S_INHIBIT;
   end

   // FSM outputs
   always_comb begin
      bus.tx_ready    = 1'b0;
      bus.tx_busy     = 1'b1;
      bus.ps2_clk_oe  = 1'b0;
      bus.ps2_data_oe = 1'b0;
      case (state_q)
         S_IDLE: begin
            bus.tx_ready = 1'b1;
            bus.tx_busy  = 1'b0;
         end
         S_INHIBIT: bus.ps2_clk_oe = 1'b1;
         S_RTS: begin
            bus.ps2_clk_oe  = 1'b1;
            bus.ps2_data_oe = 1'b1;
         end
         S_SEND:  bus.ps2_data_oe = bit_q;
         default: ;
      endcase
   end

   assign bus.tx_done = done_q;
   assign bus.tx_err  = err_q;

   // Datapath: cycle/timeout counter, frame shifter, ack capture, completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q    <= '0;
         edge_q   <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         bit_q    <= 1'b0;
         nack_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         // Restarts on entering INHIBIT/RTS/SEND only, so the timeout keeps
         // running from clock release through ACK and WAIT_IDLE.
         if ((state_d == S_IDLE) ||
             ((state_d != state_q) && (state_d inside {S_INHIBIT, S_RTS, S_SEND})))
            cyc_q <= '0;
         else if (cyc_q != '1)
            cyc_q <= cyc_q + 21'd1;

         if (enter_inh) begin
            shift_q  <= load_byte;
            parity_q <= ~^load_byte;
            edge_q   <= '0;
            bit_q    <= 1'b1;      // start bit persists until the first device edge
            nack_q   <= 1'b0;
         end else if ((state_q == S_SEND) && clk_fall) begin
            edge_q <= edge_q + 4'd1;
            if (edge_q < 4'd8) begin
               bit_q   <= ~shift_q[0];
               shift_q <= {1'b0, shift_q[7:1]};
            end else if (edge_q == 4'd8) begin
               bit_q <= ~parity_q;
            end else begin
               bit_q <= 1'b0;      // stop bit: release data
            end
         end else if ((state_q == S_ACK) && clk_fall) begin
            nack_q <= dat_s2_q;
         end

         if (finish && !(fail && can_retry)) begin
            done_q <= 1'b1;
            err_q  <= fail;
         end
      end
   end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
   localparam int INH  = 60;
   localparam int RTS  = 20;
   localparam int TO   = 3000;
   localparam int FILT = 8;
   localparam int HP   = 40;
`ifdef PS2_TX_RETRY_EN
   localparam int ATTEMPTS = 3;
`else
   localparam int ATTEMPTS = 1;
`endif

   logic clk = 1'b0;
   logic rst;
   logic bfm_clk_low  = 1'b0;
   logic bfm_data_low = 1'b0;
   logic glitch       = 1'b0;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   release_cyc = 0;
   int   inhibit_cyc = 0;
   logic prev_clk_oe = 1'b0;

   logic       done_err_q[$];
   int         done_cyc_q[$];
   int         done_rd = 0;
   logic       exp_err_q[$];
   logic [9:0] exp_frame_q[$];

   ps2_host_tx_if bus ();

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .RTS_CYCLES(RTS),
      .TIMEOUT_CYCLES(TO),
      .FILT_LEN(FILT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Open-drain lines with pull-ups: low if host, device or glitch pulls.
   assign bus.ps2_clk_in  = ~(bus.ps2_clk_oe | bfm_clk_low | glitch);
   assign bus.ps2_data_in = ~(bus.ps2_data_oe | bfm_data_low);

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.tx_done) begin
         done_err_q.push_back(bus.tx_err);
         done_cyc_q.push_back(cyc);
      end
      if (prev_clk_oe && !bus.ps2_clk_oe) release_cyc <= cyc;
      if (!prev_clk_oe && bus.ps2_clk_oe) inhibit_cyc <= cyc;
      prev_clk_oe <= bus.ps2_clk_oe;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] frame_of(input logic [7:0] b);
      logic p;
      p = (($countones(b) % 2) == 0);
      return {1'b1, p, b};
   endfunction

   task automatic start_tx(input logic [7:0] b, input int nframes);
      @(negedge clk);
      check("ready_before_accept", bus.tx_ready, 1);
      bus.tx_valid = 1'b1;
      bus.tx_data  = b;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      check("ready_drops", bus.tx_ready, 0);
      for (int a = 0; a < nframes; a++) exp_frame_q.push_back(frame_of(b));
   endtask

   task automatic bfm_frame(input bit ack, input bit do_glitch, input int abort_at,
                            output logic [9:0] bits);
      int r0;
      int n;
      r0   = release_cyc;
      n    = 0;
      bits = '0;
      while (release_cyc == r0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check("clk_released", (release_cyc != r0), 1);
      if (release_cyc == r0) return;
      repeat (20) @(negedge clk);
      check("start_bit_low", bus.ps2_data_in, 0);
      for (int i = 1; i <= 10; i++) begin
         bfm_clk_low = 1'b1;
         repeat (HP) @(negedge clk);
         if (i == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("rst_clk_oe", bus.ps2_clk_oe, 0);
            check("rst_data_oe", bus.ps2_data_oe, 0);
            check("rst_ready", bus.tx_ready, 1);
            bfm_clk_low = 1'b0;
            return;
         end
         bfm_clk_low = 1'b0;
         bits[i-1] = bus.ps2_data_in;
         if (do_glitch && i == 4) begin
            repeat (15) @(negedge clk);
            glitch = 1'b1;
            repeat (3) @(negedge clk);
            glitch = 1'b0;
            repeat (HP - 18) @(negedge clk);
         end else begin
            repeat (HP) @(negedge clk);
         end
      end
      bfm_data_low = ack;
      repeat (5) @(negedge clk);
      bfm_clk_low = 1'b1;
      repeat (HP) @(negedge clk);
      bfm_clk_low = 1'b0;
      repeat (HP / 2) @(negedge clk);
      bfm_data_low = 1'b0;
   endtask

   task automatic expect_done(input string tag, input logic exp_err);
      int n;
      n = 0;
      exp_err_q.push_back(exp_err);
      while (done_err_q.size() <= done_rd && n < 15000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_seen"}, (done_err_q.size() > done_rd), 1);
      if (done_err_q.size() > done_rd) begin
         check({tag, "_err"}, done_err_q[done_rd], exp_err_q.pop_front());
         done_rd++;
      end
   endtask

   initial begin
      logic [9:0] fr;
      logic [7:0] pbytes [3];
      logic       pbits  [3];
      int         sz;

      pbytes[0] = 8'h00; pbits[0] = 1'b1;
      pbytes[1] = 8'hFF; pbits[1] = 1'b1;
      pbytes[2] = 8'h01; pbits[2] = 1'b0;

      rst          = 1'b1;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_ready", bus.tx_ready, 1);
      check("reset_busy", bus.tx_busy, 0);
      check("reset_clk_oe", bus.ps2_clk_oe, 0);
      check("reset_data_oe", bus.ps2_data_oe, 0);
      check("reset_done", bus.tx_done, 0);
      check("reset_err", bus.tx_err, 0);

      // Basic 0xED with ack
      start_tx(8'hED, 1);
      bfm_frame(1'b1, 1'b0, 0, fr);
      check("ed_frame", fr, exp_frame_q.pop_front());
      check("ed_frame_literal", fr, 10'b11_1110_1101);
      check("ed_inhibit_len", release_cyc - inhibit_cyc, INH + RTS);
      expect_done("ed", 1'b0);

      // Parity corner bytes; tx_valid while busy must be ignored
      for (int i = 0; i < 3; i++) begin
         start_tx(pbytes[i], 1);
         if (i == 0) begin
            @(negedge clk);
            bus.tx_valid = 1'b1;
            bus.tx_data  = 8'h55;
            check("busy_during_tx", bus.tx_busy, 1);
            @(negedge clk);
            bus.tx_valid = 1'b0;
         end
         bfm_frame(1'b1, 1'b0, 0, fr);
         check("parity_bit", fr[8], pbits[i]);
         check("parity_frame", fr, exp_frame_q.pop_front());
         expect_done("parity", 1'b0);
      end

      // Nack (retried frames when the retry feature is built in)
      start_tx(8'h3C, ATTEMPTS);
      for (int a = 0; a < ATTEMPTS; a++) begin
         bfm_frame(1'b0, 1'b0, 0, fr);
         check("nack_frame", fr, exp_frame_q.pop_front());
      end
      expect_done("nack", 1'b1);

      // Glitch on the clock line mid-frame
      start_tx(8'hA6, 1);
      bfm_frame(1'b1, 1'b1, 0, fr);
      check("glitch_frame", fr, exp_frame_q.pop_front());
      expect_done("glitch", 1'b0);

      // Timeout: device never clocks
      start_tx(8'h5A, 0);
      expect_done("timeout", 1'b1);
      check("timeout_latency", done_cyc_q[done_cyc_q.size() - 1] - release_cyc, TO);
      @(negedge clk);
      check("timeout_clk_oe", bus.ps2_clk_oe, 0);
      check("timeout_data_oe", bus.ps2_data_oe, 0);

      // Reset at falling edge 5, then a clean 0xF4
      start_tx(8'h99, 0);
      sz = done_err_q.size();
      bfm_frame(1'b1, 1'b0, 5, fr);
      repeat (300) @(negedge clk);
      check("rst_no_done", done_err_q.size(), sz);
      start_tx(8'hF4, 1);
      bfm_frame(1'b1, 1'b0, 0, fr);
      check("f4_frame", fr, exp_frame_q.pop_front());
      expect_done("f4", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: the write direction of the PS/2 link whose receive side decodes keyboard scancodes.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- Drives the PS2_clk/PS2_data lines open-drain through pad-level tristates in the top level.
- Runs on the 100 MHz system clock; shares the lines with the receiver, which must ignore traffic while tx_busy=1.

Parameters:
- INHIBIT_CYCLES, 12000: cycles clock line is held low before request-to-send (120 us at 100 MHz).
- RTS_CYCLES, 2000: cycles data is held low, with clock still low, before clock release (20 us).
- TIMEOUT_CYCLES, 2000000: max cycles from clock release to ack; also the idle-wait limit (20 ms).
- FILT_LEN, 8: consecutive equal synchronized samples required to accept a new clock-line level.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous reset, active-high
- tx_valid  in  1  request to send tx_data
- tx_data  in  8  byte to send, captured on handshake
- tx_ready  out  1  high only in IDLE
- ps2_clk_in  in  1  raw clock-line level (asynchronous)
- ps2_data_in  in  1  raw data-line level (asynchronous)
- ps2_clk_oe  out  1  1 = pull clock line low, 0 = release
- ps2_data_oe  out  1  1 = pull data line low, 0 = release
- tx_busy  out  1  high in every state except IDLE
- tx_done  out  1  one-cycle pulse at end of transfer
- tx_err  out  1  valid with tx_done: 1 = no ack or timeout

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Input conditioning:
  - Both line inputs pass through a 2-flop synchronizer.
  - The clock line then passes through the FILT_LEN glitch filter.
  - Falling edge = filtered clock 1->0. Edge detection adds a fixed 2+FILT_LEN cycle lag.
- Handshake: transfer accepted when tx_valid && tx_ready; tx_data latched into a shift register; odd parity computed at accept (parity = ~^tx_data).
- States:
  - IDLE:
    - Outputs tx_ready=1, both oe=0.
    - On accept -> INHIBIT; tx_ready drops the next cycle.
  - INHIBIT:
    - Outputs clk_oe=1, data_oe=0.
    - Counts INHIBIT_CYCLES, then -> RTS.
  - RTS:
    - Outputs clk_oe=1, data_oe=1 (start bit).
    - Counts RTS_CYCLES, then -> SEND with clk_oe=0.
    - Timeout counter cleared at this transition.
  - SEND:
    - Falling-edge counter n=1..10.
    - Falling edges 1-8: data_oe=~bit[n-1], LSB first.
    - Falling edge 9: data_oe=~parity.
    - Falling edge 10: data_oe=0 (stop bit, line released) -> ACK.
  - ACK:
    - On next falling edge, sample synchronized data_in: 0 = ack, 1 = nack.
    - Then -> WAIT_IDLE.
  - WAIT_IDLE:
    - Wait until synchronized clock and data both high.
    - Then pulse tx_done, tx_err = nack, -> IDLE.
- Timeout:
  - Counter runs in SEND, ACK and WAIT_IDLE.
  - When it reaches TIMEOUT_CYCLES: both oe=0, tx_done=1, tx_err=1, -> IDLE. No retry unless the optional feature is enabled.
- tx_valid is ignored while tx_busy=1. A new transfer can be accepted the cycle after tx_done.
- Reset values: FSM=IDLE, both oe=0, tx_busy=0, tx_done=0, tx_err=0, tx_ready=1 from the first cycle after reset deasserts, all counters 0.
- Reset mid-transfer releases both lines on the next clock edge. The partially sent frame is abandoned; the device recovers by its own timeout.
- Device-driven clock activity during IDLE is ignored; the receiver owns that traffic.
- Counters:
  - Cycle counter is 21 bits and saturates; no wrap.
  - Edge counter is 4 bits.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined:
  - On nack or timeout, the FSM re-enters INHIBIT with the same latched byte, up to 2 retries.
  - tx_done/tx_err are reported only after the final attempt; tx_busy stays high across retries.
  - Retry count resets on each new accept.
- Undefined: the first failure ends the transfer with tx_err=1; no retry logic is synthesized.

Test Plan:
- Bench uses a device model (BFM) that generates a 12.5 kHz clock and samples data on rising edges.
- Basic send: tx_data=0xED, BFM acks -> BFM captures bits 1,0,1,1,0,1,1,1 LSB first, parity=1, stop=1; tx_done=1 with tx_err=0; clk_oe asserted for >= 12000 cycles beforehand.
- Parity: send 0x00 -> parity bit 1; send 0xFF -> parity bit 1; send 0x01 -> parity bit 0.
- Nack: BFM leaves data high on the 11th clock -> tx_done=1, tx_err=1. With PS2_TX_RETRY_EN, exactly 3 frames are observed before tx_done.
- Timeout: BFM never clocks after RTS -> tx_done, tx_err=1 exactly TIMEOUT_CYCLES after clock release; both oe=0.
- Glitch: inject a 3-cycle low pulse on ps2_clk_in mid-frame -> bit count unaffected, frame correct.
- Reset: assert rst for 1 cycle at edge 5 -> both oe=0 on the next cycle, tx_ready=1, tx_done never pulses; a following 0xF4 send completes cleanly.
